// File: rtl/piso_tx_pkg.sv
// Shared types and constants for the piso_tx serial transmitter.
package piso_tx_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for one frame: counts 0..WIDTH-1, wraps to 0 after the
// last bit, and flags when the last data bit is being driven.
module piso_bit_counter
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  // Next count: a new word restarts at bit 0, otherwise advance and wrap at the last bit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: accepts a word over valid/ready and
// shifts it out MSB-first, one bit per clock, flagging the first bit.
// Optional feature: define PISO_TX_PARITY_EN to append an even-parity bit.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int BACK2BACK = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] reg_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             first_q, first_d;
`ifdef PISO_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic bit_last;
  logic cnt_en;
  logic last_cycle;
  logic transfer;

  assign cnt_en = (state_q == SHIFT);

`ifdef PISO_TX_PARITY_EN
  assign last_cycle = (state_q == PARITY);
`else
  assign last_cycle = cnt_en && bit_last;
`endif

  assign in_ready = (state_q == IDLE) || ((BACK2BACK != 0) && last_cycle);
  assign transfer = in_valid && in_ready;
  assign busy     = (state_q != IDLE);

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (transfer),
    .enable (cnt_en),
    .last   (bit_last)
  );

  // Next-state logic: walk the frame bit by bit; an accepted word always
  // (re)starts a frame, which is what makes back-to-back transfers seamless.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    first_d  = 1'b0;
`ifdef PISO_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SHIFT: begin
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        if (bit_last) begin
`ifdef PISO_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (transfer) begin
      state_d  = SHIFT;
      shift_d  = reg_in;
      first_d  = 1'b1;
`ifdef PISO_TX_PARITY_EN
      parity_d = ^reg_in;
`endif
    end
  end

  // State, shift and flag registers; reset aborts any frame in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      first_q  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      first_q  <= first_d;
`ifdef PISO_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Serial outputs decoded from registered state only; quiet whenever idle.
  always_comb begin
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    ser_first = 1'b0;
    case (state_q)
      SHIFT: begin
        ser_out   = shift_q[WIDTH-1];
        ser_valid = 1'b1;
        ser_first = first_q;
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        ser_out   = parity_q;
        ser_valid = 1'b1;
      end
`endif
      default: begin
        ser_out = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_tx.sv
// Testbench for piso_tx: two instances (back-to-back on and off) driven by the
// same inputs, checked every cycle against a queue-of-pending-bits model, plus
// hand-computed directed expectations.
module tb_piso_tx;

  localparam int WIDTH = 4;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] regIn;
  logic             inValid;
  logic [1:0]       inReady;
  logic [1:0]       serOut;
  logic [1:0]       serValid;
  logic [1:0]       serFirst;
  logic [1:0]       busy;

  int passCount  = 0;
  int checkCount = 0;

  piso_tx #(.WIDTH(WIDTH), .BACK2BACK(1)) dutB2b (
    .clock     (clock),
    .reset     (reset),
    .reg_in    (regIn),
    .in_valid  (inValid),
    .in_ready  (inReady[0]),
    .ser_out   (serOut[0]),
    .ser_valid (serValid[0]),
    .ser_first (serFirst[0]),
    .busy      (busy[0])
  );

  piso_tx #(.WIDTH(WIDTH), .BACK2BACK(0)) dutGap (
    .clock     (clock),
    .reset     (reset),
    .reg_in    (regIn),
    .in_valid  (inValid),
    .in_ready  (inReady[1]),
    .ser_out   (serOut[1]),
    .ser_valid (serValid[1]),
    .ser_first (serFirst[1]),
    .busy      (busy[1])
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r);
    inValid = v;
    regIn   = d;
    reset   = r;
    @(posedge clock);
    #1;
  endtask

  // Model: each instance holds the list of {first,bit} entries still to appear
  // on the wire; the head is what is driven in the current cycle.
  logic [1:0] pend [2][0:15];
  int         pcnt [2];

  function automatic bit modelReady(input int i);
    return (pcnt[i] == 0) || ((i == 0) && (pcnt[i] == 1));
  endfunction

  // Advance the model at each edge, then compare every output of both instances.
  always @(posedge clock) begin
    bit rdy;
    for (int i = 0; i < 2; i++) begin
      rdy = modelReady(i);
      if (reset) begin
        pcnt[i] = 0;
      end else begin
        if (pcnt[i] > 0) begin
          for (int j = 0; j < 15; j++) pend[i][j] = pend[i][j+1];
          pcnt[i]--;
        end
        if (inValid && rdy) begin
          for (int k = WIDTH - 1; k >= 0; k--) begin
            pend[i][pcnt[i]] = {(k == WIDTH - 1), regIn[k]};
            pcnt[i]++;
          end
`ifdef PISO_TX_PARITY_EN
          pend[i][pcnt[i]] = {1'b0, ^regIn};
          pcnt[i]++;
`endif
        end
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("model ser_valid[%0d]", i), 32'(serValid[i]), 32'(pcnt[i] > 0));
      checkOutput($sformatf("model ser_out[%0d]", i), 32'(serOut[i]), 32'((pcnt[i] > 0) ? pend[i][0][0] : 1'b0));
      checkOutput($sformatf("model ser_first[%0d]", i), 32'(serFirst[i]), 32'((pcnt[i] > 0) ? pend[i][0][1] : 1'b0));
      checkOutput($sformatf("model busy[%0d]", i), 32'(busy[i]), 32'(pcnt[i] > 0));
      checkOutput($sformatf("model in_ready[%0d]", i), 32'(inReady[i]), 32'(modelReady(i)));
    end
  end

  // Directed scenarios with literal expectations, then a randomized run.
  initial begin
    logic [3:0] word;
    logic [7:0] seq8;
    logic [8:0] gap9;
    logic [4:0] par5;
    pcnt[0] = 0;
    pcnt[1] = 0;
    inValid = 1'b0;
    regIn   = '0;
    reset   = 1'b1;

    applyStimulus(1'b0, 4'h0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b1);
    checkOutput("reset ser_valid", 32'(serValid), 32'h0);
    checkOutput("reset ser_out", 32'(serOut), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset in_ready", 32'(inReady), 32'h3);

    // Single word 1011: bits 1,0,1,1 with ser_first only on the first.
    word = 4'b1011;
    applyStimulus(1'b1, word, 1'b0);
    checkOutput("t1 bit3", 32'(serOut[0]), 32'h1);
    checkOutput("t1 first", 32'(serFirst[0]), 32'h1);
    checkOutput("t1 in_ready", 32'(inReady[0]), 32'h0);
    for (int k = 2; k >= 0; k--) begin
      applyStimulus(1'b0, 4'h0, 1'b0);
      checkOutput($sformatf("t1 bit%0d", k), 32'(serOut[0]), 32'(word[k]));
      checkOutput($sformatf("t1 nofirst%0d", k), 32'(serFirst[0]), 32'h0);
    end
    repeat (3) applyStimulus(1'b0, 4'h0, 1'b0);

`ifndef PISO_TX_PARITY_EN
    // Back-to-back A then 5; 5 is offered early (ignored) and re-offered.
    seq8 = 8'b1010_0101;
    gap9 = 9'b1111_0_1111;
    for (int c = 0; c < 9; c++) begin
      applyStimulus((c < 6), (c == 0) ? 4'hA : 4'h5, 1'b0);
      if (c < 8) begin
        checkOutput($sformatf("t2 bit%0d", c), 32'(serOut[0]), 32'(seq8[7-c]));
        checkOutput($sformatf("t2 valid%0d", c), 32'(serValid[0]), 32'h1);
      end else begin
        checkOutput("t2 end valid", 32'(serValid[0]), 32'h0);
      end
      checkOutput($sformatf("t3 valid%0d", c), 32'(serValid[1]), 32'(gap9[8-c]));
      if (c < 4) checkOutput($sformatf("t3 ready%0d", c), 32'(inReady[1]), 32'h0);
    end
`else
    // Parity appended after the LSB.
    par5 = 5'b0111_1;
    applyStimulus(1'b1, 4'b0111, 1'b0);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) applyStimulus(1'b0, 4'h0, 1'b0);
      checkOutput($sformatf("t6a bit%0d", c), 32'(serOut[0]), 32'(par5[4-c]));
      checkOutput($sformatf("t6a valid%0d", c), 32'(serValid[0]), 32'h1);
    end
    repeat (2) applyStimulus(1'b0, 4'h0, 1'b0);
    par5 = 5'b0101_0;
    applyStimulus(1'b1, 4'b0101, 1'b0);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) applyStimulus(1'b0, 4'h0, 1'b0);
      checkOutput($sformatf("t6b bit%0d", c), 32'(serOut[0]), 32'(par5[4-c]));
    end
`endif
    repeat (3) applyStimulus(1'b0, 4'h0, 1'b0);

    // Reset during the second bit of 4'hF aborts the frame immediately.
    applyStimulus(1'b1, 4'hF, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("t4 bit2 shown", 32'(serValid[0]), 32'h1);
    applyStimulus(1'b0, 4'h0, 1'b1);
    checkOutput("t4 ser_valid", 32'(serValid[0]), 32'h0);
    checkOutput("t4 busy", 32'(busy[0]), 32'h0);
    checkOutput("t4 in_ready", 32'(inReady[0]), 32'h1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 4'h0, 1'b0);
      checkOutput($sformatf("t4 quiet%0d", c), 32'(serValid[0]), 32'h0);
    end

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom_range(0, 2) != 0), WIDTH'($urandom_range(0, 15)),
                    ($urandom_range(0, 39) == 0));
    end
    repeat (8) applyStimulus(1'b0, 4'h0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
